// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// The optional result self-check is enabled with `define DIV_SELF_CHECK_EN.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient fill used when the result is undefined (divide by zero, overflow).
  function automatic logic [63:0] all_ones_fill(input int w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then subtract the divisor when it fits.
module div_restoring_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic           w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  // The restored result is always below the divisor, so WIDTH bits suffice.
  assign o_rem   = w_ge ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
  assign o_qbit  = w_ge;

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient
// bit per clock, valid/ready on both sides. Optional self-check: DIV_SELF_CHECK_EN.
module div_restoring_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               ovf,
  output logic               chk_err,
  output state_t             dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid and data stable until that edge, ready never depends on valid.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] FILL = WIDTH'(all_ones_fill(WIDTH));

  state_t           r_state, w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_div, r_lo, r_rem, r_quot;
  logic             r_div_zero, r_ovf;
  logic             w_accept, w_release, w_dz, w_ov, w_qbit, w_chk_busy;
  logic [WIDTH-1:0] w_step_rem;

  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;
  assign w_dz      = (divisor == '0);
  assign w_ov      = (dividend[2*WIDTH-1:WIDTH] >= divisor);

  div_restoring_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_lo[WIDTH-1]),
    .i_divisor (r_div),
    .o_rem     (w_step_rem),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_dz || w_ov) ? DONE : CALC;
      CALC:    if (r_count == '0) w_next = DONE;
      DONE:    if (w_release) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE) && !w_chk_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_div      <= '0;
      r_lo       <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      r_div      <= divisor;
      r_lo       <= dividend[WIDTH-1:0];
      r_count    <= CW'(WIDTH - 1);
      r_div_zero <= w_dz;
      r_ovf      <= !w_dz && w_ov;
      if (w_dz || w_ov) begin
        r_quot <= FILL;
        r_rem  <= dividend[WIDTH-1:0];
      end else begin
        r_quot <= '0;
        r_rem  <= dividend[2*WIDTH-1:WIDTH];
      end
    end else if (r_state == CALC) begin
      r_rem   <= w_step_rem;
      r_quot  <= {r_quot[WIDTH-2:0], w_qbit};
      r_lo    <= r_lo << 1;
      r_count <= r_count - 1'b1;
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_div_zero;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

`ifdef DIV_SELF_CHECK_EN
  logic [2*WIDTH-1:0] r_dvd;
  logic               r_chk_pend, r_chk_err;
  logic [2*WIDTH-1:0] w_recon;

  assign w_recon = (2*WIDTH)'(r_quot) * (2*WIDTH)'(r_div) + (2*WIDTH)'(r_rem);

  // The comparison takes one registered cycle in DONE before out_valid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd      <= '0;
      r_chk_pend <= 1'b0;
      r_chk_err  <= 1'b0;
    end else if (r_state == IDLE && w_accept) begin
      r_dvd      <= dividend;
      r_chk_pend <= 1'b0;
      r_chk_err  <= 1'b0;
    end else if (r_state == CALC && r_count == '0) begin
      r_chk_pend <= 1'b1;
    end else if (r_chk_pend) begin
      r_chk_pend <= 1'b0;
      r_chk_err  <= (w_recon != r_dvd);
    end else if (r_state == DONE && w_release) begin
      r_chk_err  <= 1'b0;
    end
  end

  assign w_chk_busy = r_chk_pend;
  assign chk_err    = r_chk_err;
`else
  assign w_chk_busy = 1'b0;
  assign chk_err    = 1'b0;
`endif

endmodule
